cic_decimator: RTL and testbench

- Third-order CIC decimation filter: converts a 1-bit PDM/sigma-delta bitstream at the `clk` rate into 24-bit signed PCM words.
- Sits directly behind the modulator/bitstream source; its output feeds downstream PCM processing.
- Decimation instants come from the slow `dec_clk` input, which is sampled and edge-detected inside the `clk` domain. Single clock design.
- Nominal rates: `clk` 16 MHz, `dec_clk` 250 kHz, R = 64, differential delay M = 1.

---
 rtl/cic_decimator.sv | 88 ++++++++
 tb/tb_cic_decimator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// Third-order CIC decimator: 1-bit PDM bitstream at clk rate in, W-bit signed PCM out once per dec_clk rising edge.
// Registers wrap modulo 2^W on purpose; Hogenauer arithmetic keeps the comb output exact.
module cic_decimator #(
  parameter int N_STAGES = 3,
  parameter int W        = 24,
  parameter int R_NOM    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_clk,
  input  logic                in,
  output logic signed [W-1:0] out
);

  localparam int GAIN_BITS = N_STAGES * $clog2(R_NOM);

  if (GAIN_BITS >= W) begin : g_gain_check
    $error("cic_decimator: W is too narrow for the filter gain");
  end

  logic [W-1:0] x_s;
  logic [W-1:0] integ_r   [N_STAGES];
  logic [W-1:0] comb_in_s [N_STAGES];
  logic [W-1:0] delay_r   [N_STAGES];
  logic [W-1:0] comb_r    [N_STAGES];
  logic [2:0]   dec_sync_r;
  logic         strobe_s;

  // Map the bitstream sample to +1 / -1
  always_comb begin
    if (in) begin
      x_s = {{(W-1){1'b0}}, 1'b1};
    end else begin
      x_s = {W{1'b1}};
    end
  end

  // Two synchronizer flops plus one edge-detect flop for dec_clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_sync_r <= 3'b000;
    end else begin
      dec_sync_r <= {dec_sync_r[1:0], dec_clk};
    end
  end

  assign strobe_s = dec_sync_r[1] & ~dec_sync_r[2];

  // Integrator chain, every stage updated from pre-edge values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_STAGES; i++) begin
        integ_r[i] <= {W{1'b0}};
      end
    end else begin
      integ_r[0] <= integ_r[0] + x_s;
      for (int i = 1; i < N_STAGES; i++) begin
        integ_r[i] <= integ_r[i] + integ_r[i-1];
      end
    end
  end

  // Comb stage k is fed by the last integrator (k = 0) or by the previous comb
  always_comb begin
    comb_in_s[0] = integ_r[N_STAGES-1];
    for (int i = 1; i < N_STAGES; i++) begin
      comb_in_s[i] = comb_r[i-1];
    end
  end

  // Comb chain and output register, advanced only on a decimation strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_STAGES; i++) begin
        delay_r[i] <= {W{1'b0}};
        comb_r[i]  <= {W{1'b0}};
      end
      out <= {W{1'b0}};
    end else if (strobe_s) begin
      for (int i = 0; i < N_STAGES; i++) begin
        delay_r[i] <= comb_in_s[i];
        comb_r[i]  <= comb_in_s[i] - delay_r[i];
      end
      out <= $signed(comb_r[N_STAGES-1]);
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: density patterns against R^3 * mean(x),
// asynchronous reset behaviour and dec_clk edge-to-strobe timing.
module tb_cic_decimator;

  localparam int R         = 64;
  localparam int GAIN      = R * R * R;
  // Output is exact once the three comb delays hold samples of a fully ramped integrator cascade.
  localparam int SETTLE    = 7;

  logic               clk;
  logic               rst;
  logic               dec_clk;
  logic               in;
  logic signed [23:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [23:0] exp_q[$];

  cic_decimator dut (
    .clk     (clk),
    .rst     (rst),
    .dec_clk (dec_clk),
    .in      (in),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive a repeating pattern with 64-clk strobe spacing; compare each settled strobe's output.
  task automatic run_pattern(input string name, input logic [3:0] pat, input int plen,
                             input int n_strobes);
    int ones;
    int t;
    int exp_full;
    logic signed [23:0] exp_v;
    ones = 0;
    for (int i = 0; i < plen; i++) begin
      if (pat[i]) ones++;
    end
    exp_full = ((2 * ones - plen) * GAIN) / plen;
    dec_clk = 1'b0;
    do_reset();
    exp_q.delete();
    t = 0;
    for (int s = 1; s <= n_strobes; s++) begin
      for (int c = 0; c < R; c++) begin
        @(negedge clk);
        in = pat[t % plen];
        t++;
        if (c == 0) begin
          dec_clk = 1'b1;
          if (s >= SETTLE) exp_q.push_back(exp_full[23:0]);
        end
        if (c == R / 2) dec_clk = 1'b0;
        if (c == 4 && s >= SETTLE) begin
          exp_v = exp_q.pop_front();
          n_tests++;
          if (out !== exp_v) begin
            n_fail++;
            $display("FAIL %s strobe %0d: out=%0d (0x%06h) expected %0d (0x%06h)",
                     name, s, out, out, exp_v, exp_v);
          end
        end
      end
    end
  endtask

  task automatic test_reset_state();
    rst = 1'b1;
    dec_clk = 1'b0;
    in = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out !== 24'sd0) begin
      n_fail++;
      $display("FAIL reset_state: out=0x%06h expected 0x000000", out);
    end
    rst = 1'b0;
  endtask

  task automatic test_constant_one();
    run_pattern("const_one", 4'b0001, 1, 12);
  endtask

  task automatic test_constant_zero();
    run_pattern("const_zero", 4'b0000, 1, 12);
  endtask

  task automatic test_alternating();
    run_pattern("alternating", 4'b0001, 2, 12);
  endtask

  // Integrators wrap within a few hundred clocks, so a long run stresses modular arithmetic.
  task automatic test_density_75();
    run_pattern("density_75", 4'b0111, 4, 40);
  endtask

  task automatic test_reset();
    run_pattern("pre_reset", 4'b0001, 1, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in = 1'($urandom_range(0, 1));
      if (i == 10) begin
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out !== 24'sd0) begin
          n_fail++;
          $display("FAIL reset_immediate: out=0x%06h expected 0x000000", out);
        end
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (dut.integ_r[k] !== 24'd0 || dut.delay_r[k] !== 24'd0 || dut.comb_r[k] !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_state_stage%0d: integ=0x%06h delay=0x%06h comb=0x%06h expected 0",
                     k, dut.integ_r[k], dut.delay_r[k], dut.comb_r[k]);
          end
        end
        n_tests++;
        if (dut.dec_sync_r !== 3'b000) begin
          n_fail++;
          $display("FAIL reset_sync: sync=%b expected 000", dut.dec_sync_r);
        end
        @(negedge clk);
        rst = 1'b0;
      end
    end
    n_tests++;
    if (out !== 24'sd0) begin
      n_fail++;
      $display("FAIL reset_hold: out=0x%06h expected 0x000000", out);
    end
    dec_clk = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (out !== 24'sd0) begin
      n_fail++;
      $display("FAIL reset_first_strobe: out=0x%06h expected 0x000000", out);
    end
    dec_clk = 1'b0;
  endtask

  task automatic test_reset_vs_strobe();
    run_pattern("pre_collision", 4'b0001, 1, 8);
    @(negedge clk);
    dec_clk = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (dut.strobe_s !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_strobe: strobe=%b expected 1", dut.strobe_s);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (out !== 24'sd0 || dut.comb_r[2] !== 24'd0) begin
      n_fail++;
      $display("FAIL collision_reset_wins: out=0x%06h comb3=0x%06h expected 0", out, dut.comb_r[2]);
    end
    dec_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // dec_clk edges land off the clk grid; count strobe cycles after each edge.
  task automatic test_strobe_timing();
    int cnt;
    for (int e = 0; e < 8; e++) begin
      #($urandom_range(30, 200));
      if (($time % 5) == 0) #1;
      dec_clk = 1'b1;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (dut.strobe_s === 1'b1) cnt++;
      end
      n_tests++;
      if (cnt !== 1) begin
        n_fail++;
        $display("FAIL strobe_rise edge %0d: strobes=%0d expected 1", e, cnt);
      end
      #($urandom_range(30, 200));
      if (($time % 5) == 0) #1;
      dec_clk = 1'b0;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (dut.strobe_s === 1'b1) cnt++;
      end
      n_tests++;
      if (cnt !== 0) begin
        n_fail++;
        $display("FAIL strobe_fall edge %0d: strobes=%0d expected 0", e, cnt);
      end
    end
  endtask

  initial begin
    test_reset_state();
    test_constant_one();
    test_constant_zero();
    test_alternating();
    test_density_75();
    test_reset();
    test_reset_vs_strobe();
    test_strobe_timing();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
